// File: rtl/conv_window_shift_pkg.sv
// rtl/conv_window_shift_pkg.sv - shared types, defaults and stride clamp for the conv window shifter
package conv_window_shift_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int LEN_DEF    = 8;
  localparam int CH_DEF     = 1;

  typedef logic [DATA_W_DEF-1:0]  sample_t;
  typedef sample_t [LEN_DEF-1:0]  window_t;

  typedef enum logic {FILL, SLIDE} win_state_e;

  // Out-of-range strides are folded into 1..len.
  function automatic int clamp_stride(input int stride, input int len);
    if (stride < 1) return 1;
    if (stride > len) return len;
    return stride;
  endfunction

endpackage

// File: rtl/conv_window_shift_lane.sv
// rtl/conv_window_shift_lane.sv - single-channel LEN-tap shift register, tap 0 oldest
module conv_lane_shift #(
  parameter int DATA_W = 16,
  parameter int LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_shift,
  input  logic [DATA_W-1:0]     i_sample,
  output logic [LEN*DATA_W-1:0] o_taps
);

  logic [LEN-1:0][DATA_W-1:0] r_taps;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_taps <= '0;
    else if (i_clear) r_taps <= '0;
    else if (i_shift) r_taps <= {i_sample, r_taps[LEN-1:1]};
  end

  assign o_taps = r_taps;

endmodule

// File: rtl/conv_window_shift.sv
// rtl/conv_window_shift.sv - sliding-window shifter feeding the MAC stage, CH lanes on one handshake
module conv_window_shift
  import conv_window_shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN    = LEN_DEF,
  parameter int CH     = CH_DEF,
  parameter int CNT_W  = $clog2(LEN+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic [CNT_W-1:0]           i_cfg_stride,
  input  logic [CH*DATA_W-1:0]       i_in_data,
  input  logic                       i_in_valid,
  input  logic                       i_in_last,
  output logic                       o_in_ready,
  output logic [CH*LEN*DATA_W-1:0]   o_out_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready
);

  win_state_e       r_state;
  logic [CNT_W-1:0] r_fill_cnt;
  logic [CNT_W-1:0] r_stride_cnt;
  logic [CNT_W-1:0] r_stride;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_take;
  logic             w_new_win;
  logic [CNT_W-1:0] w_fill_next;
  logic [CNT_W-1:0] w_stride_next;

  assign o_in_ready    = !(r_out_valid && !i_out_ready);
  assign w_accept      = i_in_valid && o_in_ready;
  assign w_take        = r_out_valid && i_out_ready;
  assign w_fill_next   = r_fill_cnt + 1'b1;
  assign w_stride_next = r_stride_cnt + 1'b1;
  assign w_new_win     = w_accept &&
                         (((r_state == FILL) && (w_fill_next == CNT_W'(LEN))) ||
                          ((r_state == SLIDE) && (w_stride_next == r_stride)));
  assign o_out_valid   = r_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FILL;
      r_fill_cnt   <= '0;
      r_stride_cnt <= '0;
      r_stride     <= CNT_W'(1);
      r_out_valid  <= 1'b0;
    end else if (i_clear) begin
      r_state      <= FILL;
      r_fill_cnt   <= '0;
      r_stride_cnt <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_fill_cnt == '0)
          r_stride <= CNT_W'(clamp_stride(int'(i_cfg_stride), LEN));
        // Row end wins over counting; a window completed by this sample is still flagged below.
        if (i_in_last) begin
          r_state      <= FILL;
          r_fill_cnt   <= '0;
          r_stride_cnt <= '0;
        end else if (r_state == FILL) begin
          r_fill_cnt <= w_fill_next;
          if (w_fill_next == CNT_W'(LEN)) begin
            r_stride_cnt <= '0;
            r_state      <= SLIDE;
          end
        end else begin
          r_stride_cnt <= (w_stride_next == r_stride) ? '0 : w_stride_next;
        end
      end
      if (w_new_win)   r_out_valid <= 1'b1;
      else if (w_take) r_out_valid <= 1'b0;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    conv_lane_shift #(
      .DATA_W (DATA_W),
      .LEN    (LEN)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (i_clear),
      .i_shift  (w_accept),
      .i_sample (i_in_data[c*DATA_W +: DATA_W]),
      .o_taps   (o_out_data[c*LEN*DATA_W +: LEN*DATA_W])
    );
  end

endmodule

// File: tb/tb_conv_window_shift.sv
// tb/tb_conv_window_shift.sv - self-checking bench for conv_window_shift (LEN=4, CH=2, DATA_W=8)
module tb_conv_window_shift;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int C  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [2:0]    cfg_stride = 3'd1;
  logic [15:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;

  int vectors = 0;
  int fails = 0;

  logic [63:0] taken[$];

  // Reference model: row sample count n, window whenever n >= L and (n - L) % stride == 0.
  logic [7:0] m_tap [C][L];
  int         m_n = 0;
  int         m_stride = 1;
  bit         m_valid = 0;

  always #5 clk = ~clk;

  conv_window_shift #(.DATA_W(DW), .LEN(L), .CH(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (clear),
    .i_cfg_stride (cfg_stride),
    .i_in_data    (in_data),
    .i_in_valid   (in_valid),
    .i_in_last    (in_last),
    .o_in_ready   (in_ready),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_win(input int a);
    logic [63:0] w;
    w = '0;
    for (int t = 0; t < L; t++) begin
      w[t*8 +: 8]     = 8'(a + t);
      w[(L+t)*8 +: 8] = 8'(a + 100 + t);
    end
    return w;
  endfunction

  function automatic logic [63:0] model_data();
    logic [63:0] w;
    for (int c = 0; c < C; c++)
      for (int t = 0; t < L; t++)
        w[(c*L+t)*8 +: 8] = m_tap[c][t];
    return w;
  endfunction

  initial begin
    for (int c = 0; c < C; c++) for (int t = 0; t < L; t++) m_tap[c][t] = '0;
    forever begin
      bit acc, take, win;
      int s;
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int c = 0; c < C; c++) for (int t = 0; t < L; t++) m_tap[c][t] = '0;
        m_n = 0; m_valid = 0; m_stride = 1;
      end else if (clear) begin
        for (int c = 0; c < C; c++) for (int t = 0; t < L; t++) m_tap[c][t] = '0;
        m_n = 0; m_valid = 0;
      end else begin
        acc  = in_valid && !(m_valid && !out_ready);
        take = m_valid && out_ready;
        win  = 0;
        if (acc) begin
          if (m_n == 0) begin
            s = int'(cfg_stride);
            m_stride = (s < 1) ? 1 : (s > L) ? L : s;
          end
          for (int c = 0; c < C; c++) begin
            for (int t = 0; t < L-1; t++) m_tap[c][t] = m_tap[c][t+1];
            m_tap[c][L-1] = in_data[c*8 +: 8];
          end
          m_n++;
          win = (m_n >= L) && (((m_n - L) % m_stride) == 0);
          if (in_last) m_n = 0;
        end
        if (win) m_valid = 1;
        else if (take) m_valid = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", 64'(in_ready), 64'(!(m_valid && !out_ready)));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_data", out_data, model_data());
      if (out_valid && out_ready && !clear && !rst) taken.push_back(out_data);
    end
  end

  task automatic send(input int a, input bit last);
    bit acc;
    int n;
    acc = 0; n = 0;
    in_valid = 1; in_data = {8'(a + 100), 8'(a)}; in_last = last;
    while (!acc && n < 200) begin
      @(negedge clk); acc = in_ready; n++;
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0;
    if (!acc) begin
      vectors++; fails++;
      $display("FAIL send_timeout: sample %0d never accepted, required accept within 200 cycles", a);
    end
  endtask

  task automatic do_clear();
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    taken.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #12 rst = 0;
    @(posedge clk); #1;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_taps", out_data, 64'd0);

    // 1: stride 1, back-to-back
    cfg_stride = 1; out_ready = 1; do_clear();
    for (int a = 1; a <= 3; a++) send(a, 0);
    chk("t1_no_early_valid", 64'(out_valid), 64'd0);
    send(4, 0);
    chk("t1_valid_after_4", 64'(out_valid), 64'd1);
    chk("t1_first_window_literal", out_data, 64'h68676665_04030201);
    send(5, 0); send(6, 0);
    idle(3);
    chk("t1_count", 64'(taken.size()), 64'd3);
    for (int i = 0; i < taken.size() && i < 3; i++) chk("t1_win", taken[i], exp_win(1 + i));

    // 2: stride 2, then stride 0 behaving as 1
    cfg_stride = 2; do_clear();
    for (int a = 1; a <= 8; a++) send(a, 0);
    idle(3);
    chk("t2_count", 64'(taken.size()), 64'd3);
    for (int i = 0; i < taken.size() && i < 3; i++) chk("t2_win", taken[i], exp_win(1 + 2*i));
    cfg_stride = 0; do_clear();
    for (int a = 1; a <= 6; a++) send(a, 0);
    idle(3);
    chk("t2_s0_count", 64'(taken.size()), 64'd3);
    if (taken.size() > 1) chk("t2_s0_win1", taken[1], exp_win(2));

    // 3: back-pressure holds the window and stalls input
    cfg_stride = 1; out_ready = 0; do_clear();
    for (int a = 1; a <= 4; a++) send(a, 0);
    in_valid = 1; in_data = {8'd105, 8'd5};
    repeat (10) begin
      @(negedge clk);
      chk("t3_stall_ready", 64'(in_ready), 64'd0);
      chk("t3_hold_data", out_data, exp_win(1));
    end
    @(posedge clk); #1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    chk("t3_new_valid", 64'(out_valid), 64'd1);
    chk("t3_new_window", out_data, exp_win(2));
    chk("t3_taken_first", (taken.size() > 0) ? taken[0] : 64'hx, exp_win(1));
    idle(2);

    // 4: row boundary
    do_clear();
    for (int a = 1; a <= 5; a++) send(a, a == 5);
    for (int a = 10; a <= 13; a++) send(a, 0);
    idle(3);
    chk("t4_count", 64'(taken.size()), 64'd3);
    if (taken.size() == 3) begin
      chk("t4_w0", taken[0], exp_win(1));
      chk("t4_w1", taken[1], exp_win(2));
      chk("t4_w2", taken[2], exp_win(10));
    end

    // 5: clear early and while a window is pending
    do_clear();
    send(1, 0); send(2, 0);
    do_clear();
    chk("t5_clear_valid", 64'(out_valid), 64'd0);
    chk("t5_clear_taps", out_data, 64'd0);
    out_ready = 0;
    for (int a = 1; a <= 3; a++) send(a, 0);
    chk("t5_refill_3", 64'(out_valid), 64'd0);
    send(4, 0);
    chk("t5_refill_4", 64'(out_valid), 64'd1);
    in_valid = 1; in_data = 16'h6363;
    do_clear();
    in_valid = 0;
    chk("t5_pending_cleared", 64'(out_valid), 64'd0);
    chk("t5_pending_taps", out_data, 64'd0);
    for (int a = 1; a <= 3; a++) send(a, 0);
    chk("t5_again_3", 64'(out_valid), 64'd0);
    send(4, 0);
    chk("t5_again_4", 64'(out_valid), 64'd1);

    // 6: async reset mid-SLIDE
    out_ready = 1; do_clear();
    for (int a = 1; a <= 5; a++) send(a, 0);
    #3 rst = 1;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_taps", out_data, 64'd0);
    @(posedge clk); #3 rst = 0;
    out_ready = 0;
    for (int a = 1; a <= 3; a++) send(a, 0);
    chk("t6_after_3", 64'(out_valid), 64'd0);
    send(4, 0);
    chk("t6_after_4", 64'(out_valid), 64'd1);

    // Random traffic against the model
    repeat (3000) begin
      @(posedge clk); #1;
      in_valid   = ($urandom_range(3) != 0);
      in_data    = 16'($urandom);
      in_last    = ($urandom_range(7) == 0);
      out_ready  = ($urandom_range(2) != 0);
      clear      = ($urandom_range(63) == 0);
      if ($urandom_range(15) == 0) cfg_stride = 3'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; clear = 0; out_ready = 1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
